// File: rtl/data_sram_resp_pkg.sv
// ============================================================================
// Module      : data_sram_resp_pkg
// Description : Shared constants and FSM encoding for the data SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_sram_resp_pkg;

    localparam logic [31:0] DSRAM_BASE = 32'h1c00_0000;
    localparam int          BE_WID     = 4;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dsram_state_e;

endpackage

`default_nettype wire

// File: rtl/data_sram_resp_bank.sv
// ============================================================================
// Module      : dsram_bank
// Description : DEPTH x 32 array, byte-masked port A, full-word port B,
//               one registered read-first read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsram_bank
    import data_sram_resp_pkg::*;
#(
    parameter int ADDR_WID = 12
) (
    input  logic                clk,
    input  logic [BE_WID-1:0]   i_a_we,
    input  logic [ADDR_WID-1:0] i_a_addr,
    input  logic [31:0]         i_a_wdata,
    input  logic                i_b_en,
    input  logic [ADDR_WID-1:0] i_b_addr,
    input  logic [31:0]         i_b_wdata,
    input  logic                i_rd_en,
    input  logic [ADDR_WID-1:0] i_rd_addr,
    output logic [31:0]         o_rd_data
);

    localparam int DEPTH = 2 ** ADDR_WID;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd_data;

    // Port B is written last so it wins a same-word collision with port A.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
        for (int i = 0; i < BE_WID; i++) begin
            if (i_a_we[i]) begin
                r_mem[i_a_addr][8*i +: 8] <= i_a_wdata[8*i +: 8];
            end
        end
        if (i_b_en) begin
            r_mem[i_b_addr] <= i_b_wdata;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/data_sram_resp.sv
// ============================================================================
// Module      : data_sram_resp
// Description : Data SRAM responder: clear sequencer, range check, 1-cycle
//               read data, error pulse and access counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int          ADDR_WID     = 12,
    parameter logic [31:0] BASE_ADDR    = DSRAM_BASE,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_sram_en,
    input  logic [BE_WID-1:0]   data_sram_we,
    input  logic [31:0]         data_sram_addr,
    input  logic [31:0]         data_sram_wdata,
    output logic [31:0]         data_sram_rdata,
    output logic                data_sram_err,
    output logic                init_done,
    input  logic                ld_en,
    input  logic [ADDR_WID-1:0] ld_addr,
    input  logic [31:0]         ld_wdata,
    output logic [31:0]         rd_cnt,
    output logic [31:0]         wr_cnt
);

    localparam int                 DEPTH  = 2 ** ADDR_WID;
    localparam logic [31:0]        c_SPAN = 32'(DEPTH * 4);
    localparam logic [ADDR_WID-1:0] c_LAST = ADDR_WID'(DEPTH - 1);
    localparam logic [ADDR_WID-1:0] c_ONE  = ADDR_WID'(1);

    dsram_state_e          r_state;
    dsram_state_e          w_state_nxt;
    logic [ADDR_WID-1:0]   r_clr_ptr;
    logic                  r_err;
    logic                  r_zero;
    logic [31:0]           r_rd_cnt;
    logic [31:0]           r_wr_cnt;

    logic [31:0]           w_off;
    logic                  w_in_range;
    logic [ADDR_WID-1:0]   w_idx;
    logic                  w_clear;
    logic                  w_acc;
    logic                  w_rd;
    logic                  w_wr;
    logic [BE_WID-1:0]     w_a_we;
    logic [ADDR_WID-1:0]   w_a_addr;
    logic [31:0]           w_a_wdata;
    logic [31:0]           w_bank_q;

    assign w_off      = data_sram_addr - BASE_ADDR;
    assign w_in_range = (data_sram_addr >= BASE_ADDR) && (w_off < c_SPAN);
    assign w_idx      = w_off[ADDR_WID+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
            r_clr_ptr <= '0;
            r_err     <= 1'b0;
            r_zero    <= 1'b1;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_clr_ptr <= r_clr_ptr + c_ONE;
            end
            r_err <= data_sram_en && !w_acc;
            // rdata is forced to zero after a rejected request and holds when idle.
            if (data_sram_en) begin
                r_zero <= !w_acc;
            end
            if (w_rd) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_wr) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_acc       = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clear = 1'b1;
                if (r_clr_ptr == c_LAST) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_acc = data_sram_en && w_in_range;
            end
            default: w_state_nxt = ST_READY;
        endcase
    end

    assign w_rd = w_acc && (data_sram_we == '0);
    assign w_wr = w_acc && (data_sram_we != '0);

    always_comb begin
        w_a_we    = '0;
        w_a_addr  = w_idx;
        w_a_wdata = data_sram_wdata;
        if (w_clear) begin
            w_a_we    = '1;
            w_a_addr  = r_clr_ptr;
            w_a_wdata = '0;
        end else if (w_wr) begin
            w_a_we    = data_sram_we;
        end
    end

    dsram_bank #(
        .ADDR_WID (ADDR_WID)
    ) u_bank (
        .clk       (clk),
        .i_a_we    (w_a_we),
        .i_a_addr  (w_a_addr),
        .i_a_wdata (w_a_wdata),
        .i_b_en    (ld_en),
        .i_b_addr  (ld_addr),
        .i_b_wdata (ld_wdata),
        .i_rd_en   (w_acc),
        .i_rd_addr (w_idx),
        .o_rd_data (w_bank_q)
    );

    assign data_sram_rdata = r_zero ? 32'h0 : w_bank_q;
    assign data_sram_err   = r_err;
    assign init_done       = (r_state == ST_READY);
    assign rd_cnt          = r_rd_cnt;
    assign wr_cnt          = r_wr_cnt;

endmodule

`default_nettype wire
